// File: rtl/ic_test_sequencer.sv
// Logic-IC tester sequencer: decodes the part number, walks the four 2-input
// vectors across every gate, samples synchronised outputs and reports a verdict.
//
// state  | meaning
// IDLE   | waiting for start, results held
// DECODE | map latched number to gate function and active mask
// APPLY  | drive pins for vector k
// SETTLE | wait SETTLE_CYCLES for pins and synchroniser
// SAMPLE | compare synchronised outputs, accumulate errors
// REPORT | publish verdict, pulse done, release pins
module ic_test_sequencer #(
    parameter int SETTLE_CYCLES = 50,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        Rkey,
    input  logic        start,
    input  logic [31:0] ic_number,
    input  logic [5:0]  gate_out,
    output logic [5:0]  drv_a,
    output logic [5:0]  drv_b,
    output logic        busy,
    output logic        done,
    output logic        unsupported,
    output logic [5:0]  pass_vec,
    output logic [5:0]  fail_vec,
    output logic        pass,
    output logic        fail
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    typedef enum logic [2:0] {
        FN_NAND,
        FN_NOR,
        FN_NOT,
        FN_AND,
        FN_OR,
        FN_XOR
    } fn_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [5:0]       MASK_QUAD = 6'b001111;
    localparam logic [5:0]       MASK_HEX  = 6'b111111;

    state_t           state_q, state_d;
    fn_t              fn_q, fn_d;
    logic [31:0]      ic_q, ic_d;
    logic [5:0]       mask_q, mask_d;
    logic [1:0]       k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       sync1_q, sync2_q;
    logic [5:0]       err_q, err_d;
    logic [5:0]       drv_a_q, drv_a_d;
    logic [5:0]       drv_b_q, drv_b_d;
    logic             unsupported_q, unsupported_d;
    logic [5:0]       pass_vec_q, pass_vec_d;
    logic [5:0]       fail_vec_q, fail_vec_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    fn_t        fn_dec;
    logic       supported_dec;
    logic [5:0] mask_dec;
    logic [5:0] expect_w;

    always_comb begin
        fn_dec        = FN_AND;
        supported_dec = 1'b1;
        mask_dec      = MASK_QUAD;
        case (ic_q)
            32'd7400: fn_dec = FN_NAND;
            32'd7402: fn_dec = FN_NOR;
            32'd7404: begin
                fn_dec   = FN_NOT;
                mask_dec = MASK_HEX;
            end
            32'd7408: fn_dec = FN_AND;
            32'd7432: fn_dec = FN_OR;
            32'd7486: fn_dec = FN_XOR;
            default: begin
                supported_dec = 1'b0;
                mask_dec      = 6'd0;
            end
        endcase
    end

    // Expected response is derived from the pins actually being driven.
    always_comb begin
        expect_w = 6'd0;
        case (fn_q)
            FN_NAND: expect_w = ~(drv_a_q & drv_b_q);
            FN_NOR:  expect_w = ~(drv_a_q | drv_b_q);
            FN_NOT:  expect_w = ~drv_a_q;
            FN_AND:  expect_w = drv_a_q & drv_b_q;
            FN_OR:   expect_w = drv_a_q | drv_b_q;
            FN_XOR:  expect_w = drv_a_q ^ drv_b_q;
            default: expect_w = 6'd0;
        endcase
    end

    always_comb begin
        logic [5:0] err_new;
        logic [1:0] k_nxt;

        state_d       = state_q;
        fn_d          = fn_q;
        ic_d          = ic_q;
        mask_d        = mask_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        drv_a_d       = drv_a_q;
        drv_b_d       = drv_b_q;
        unsupported_d = unsupported_q;
        pass_vec_d    = pass_vec_q;
        fail_vec_d    = fail_vec_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        err_new       = err_q | ((sync2_q ^ expect_w) & mask_q);
        k_nxt         = k_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ic_d          = ic_number;
                    unsupported_d = 1'b0;
                    pass_vec_d    = 6'd0;
                    fail_vec_d    = 6'd0;
                    pass_d        = 1'b0;
                    fail_d        = 1'b0;
                    state_d       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                fn_d   = fn_dec;
                mask_d = mask_dec;
                if (!supported_dec) begin
                    unsupported_d = 1'b1;
                    state_d       = ST_REPORT;
                end else begin
                    k_d     = 2'd0;
                    cnt_d   = '0;
                    err_d   = 6'd0;
                    drv_a_d = 6'd0;
                    drv_b_d = 6'd0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                err_d = err_new;
                if (k_q == 2'd3) begin
                    drv_a_d    = 6'd0;
                    drv_b_d    = 6'd0;
                    pass_vec_d = mask_q & ~err_new;
                    fail_vec_d = mask_q & err_new;
                    pass_d     = (mask_q != 6'd0) && ((err_new & mask_q) == 6'd0);
                    fail_d     = |(err_new & mask_q);
                    state_d    = ST_REPORT;
                end else begin
                    k_d     = k_nxt;
                    drv_a_d = {6{k_nxt[1]}} & mask_q;
                    drv_b_d = (fn_q == FN_NOT) ? 6'd0 : ({6{k_nxt[0]}} & mask_q);
                    state_d = ST_APPLY;
                end
            end
            ST_REPORT: begin
                drv_a_d = 6'd0;
                drv_b_d = 6'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rkey) begin
        if (!Rkey) begin
            state_q       <= ST_IDLE;
            fn_q          <= FN_AND;
            ic_q          <= 32'd0;
            mask_q        <= 6'd0;
            k_q           <= 2'd0;
            cnt_q         <= '0;
            sync1_q       <= 6'd0;
            sync2_q       <= 6'd0;
            err_q         <= 6'd0;
            drv_a_q       <= 6'd0;
            drv_b_q       <= 6'd0;
            unsupported_q <= 1'b0;
            pass_vec_q    <= 6'd0;
            fail_vec_q    <= 6'd0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fn_q          <= fn_d;
            ic_q          <= ic_d;
            mask_q        <= mask_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            sync1_q       <= gate_out;
            sync2_q       <= sync1_q;
            err_q         <= err_d;
            drv_a_q       <= drv_a_d;
            drv_b_q       <= drv_b_d;
            unsupported_q <= unsupported_d;
            pass_vec_q    <= pass_vec_d;
            fail_vec_q    <= fail_vec_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
        end
    end

    assign busy        = (state_q == ST_DECODE) || (state_q == ST_APPLY) ||
                         (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done        = (state_q == ST_REPORT);
    assign drv_a       = drv_a_q;
    assign drv_b       = drv_b_q;
    assign unsupported = unsupported_q;
    assign pass_vec    = pass_vec_q;
    assign fail_vec    = fail_vec_q;
    assign pass        = pass_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Bench for ic_test_sequencer: emulated socket with stuck-at faults, table of
// directed runs, reset/busy corner sequences and randomized runs vs a model.
module tb_ic_test_sequencer;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        Rkey;
    logic        start;
    logic [31:0] ic_number;
    logic [5:0]  gate_out;
    logic [5:0]  drv_a, drv_b, pass_vec, fail_vec;
    logic        busy, done, unsupported, pass, fail;

    int          n_vec  = 0;
    int          n_miss = 0;

    int          chip;
    logic [5:0]  s1, s0, junk;

    typedef struct {
        int         ic;
        int         chip;
        logic [5:0] s1;
        logic [5:0] s0;
        logic [5:0] jk;
        logic [5:0] pv;
        logic [5:0] fv;
        logic       p;
        logic       f;
        logic       u;
        int         inject;
    } run_t;

    ic_test_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .Rkey(Rkey), .start(start), .ic_number(ic_number),
        .gate_out(gate_out), .drv_a(drv_a), .drv_b(drv_b), .busy(busy),
        .done(done), .unsupported(unsupported), .pass_vec(pass_vec),
        .fail_vec(fail_vec), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    function automatic logic supported(input int p);
        return (p == 7400) || (p == 7402) || (p == 7404) ||
               (p == 7408) || (p == 7432) || (p == 7486);
    endfunction

    function automatic logic truth(input int p, input logic a, input logic b);
        case (p)
            7400:    return ~(a & b);
            7402:    return ~(a | b);
            7404:    return ~a;
            7408:    return a & b;
            7432:    return a | b;
            7486:    return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    // What the physical chip in the socket produces on gate g (before faults).
    function automatic logic chip_out(input int chp, input int g, input logic a,
                                      input logic b, input logic [5:0] jk);
        if (supported(chp) && (chp == 7404 || g < 4)) return truth(chp, a, b);
        return jk[g];
    endfunction

    always_comb begin
        gate_out = 6'd0;
        for (int g = 0; g < 6; g++)
            gate_out[g] = (chip_out(chip, g, drv_a[g], drv_b[g], junk) & ~s0[g]) | s1[g];
    end

    function automatic logic [5:0] mask_of(input int ic);
        if (ic == 7404) return 6'h3F;
        if (supported(ic)) return 6'h0F;
        return 6'h00;
    endfunction

    // Reference verdict: try every vector on every active gate.
    function automatic run_t with_model(input run_t r);
        run_t       o;
        logic [5:0] m, err;
        logic       a, b, act;
        o   = r;
        m   = mask_of(r.ic);
        err = 6'd0;
        for (int k = 0; k < 4; k++) begin
            a = ((k >> 1) & 1) != 0;
            b = (r.ic == 7404) ? 1'b0 : ((k & 1) != 0);
            for (int g = 0; g < 6; g++) begin
                if (m[g]) begin
                    act = (chip_out(r.chip, g, a, b, r.jk) & ~r.s0[g]) | r.s1[g];
                    if (act != truth(r.ic, a, b)) err[g] = 1'b1;
                end
            end
        end
        o.pv = m & ~err;
        o.fv = m & err;
        o.p  = (m != 6'd0) && ((m & err) == 6'd0);
        o.f  = |(m & err);
        o.u  = !supported(r.ic);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_run(input run_t r);
        logic [5:0] m, uns_drv, ea, eb;
        int         done_cyc, exp_done, limit, ap, sp;
        m        = mask_of(r.ic);
        chip     = r.chip;
        s1       = r.s1;
        s0       = r.s0;
        junk     = r.jk;
        uns_drv  = 6'd0;
        done_cyc = 0;
        exp_done = supported(r.ic) ? 2 + 4 * (S + 2) : 2;
        limit    = 2 + 4 * (S + 2) + 10;
        @(posedge clk);
        #1 start = 1'b1;
        ic_number = r.ic;
        @(posedge clk);
        #1 start = 1'b0;
        ic_number = $urandom;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_decode", {31'd0, busy}, 32'd1);
                chk("cleared_on_start", {pass_vec, fail_vec, pass, fail, unsupported}, 32'd0);
            end
            if (supported(r.ic)) begin
                for (int k = 0; k < 4; k++) begin
                    ap = 2 + k * (S + 2);
                    sp = ap + S + 1;
                    ea = ((k & 2) != 0) ? m : 6'd0;
                    eb = (r.ic != 7404 && (k & 1) != 0) ? m : 6'd0;
                    if (cyc == ap) chk("drv_apply", {drv_a, drv_b}, {20'd0, ea, eb});
                    if (cyc == sp) chk("drv_sample", {drv_a, drv_b}, {20'd0, ea, eb});
                end
            end else begin
                uns_drv = uns_drv | drv_a | drv_b;
            end
            if (r.inject > 0 && cyc == r.inject) begin
                start     = 1'b1;
                ic_number = 32'd7486;
            end
            if (r.inject > 0 && cyc == r.inject + 1) start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got no done, want done at cycle %0d", exp_done);
            return;
        end
        chk("done_cycle", done_cyc, exp_done);
        chk("busy_report", {31'd0, busy}, 32'd0);
        chk("drv_report", {drv_a, drv_b}, 32'd0);
        if (!supported(r.ic)) chk("uns_drv_idle", {26'd0, uns_drv}, 32'd0);
        chk("pass_vec", {26'd0, pass_vec}, {26'd0, r.pv});
        chk("fail_vec", {26'd0, fail_vec}, {26'd0, r.fv});
        chk("pass", {31'd0, pass}, {31'd0, r.p});
        chk("fail", {31'd0, fail}, {31'd0, r.f});
        chk("unsupported", {31'd0, unsupported}, {31'd0, r.u});
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("result_hold", {pass_vec, fail_vec, pass, fail, unsupported},
            {r.pv, r.fv, r.p, r.f, r.u});
    endtask

    run_t tbl [11];
    run_t rr;
    int   parts [6] = '{7400, 7402, 7404, 7408, 7432, 7486};

    initial begin
        tbl[0]  = '{7408, 7408, 6'h00, 6'h00, 6'h00, 6'h0F, 6'h00, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{7400, 7400, 6'h04, 6'h00, 6'h00, 6'h0B, 6'h04, 1'b0, 1'b1, 1'b0, 0};
        tbl[2]  = '{7404, 7404, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{9999, 7408, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 0};
        tbl[4]  = '{7408, 7408, 6'h00, 6'h00, 6'h00, 6'h0F, 6'h00, 1'b1, 1'b0, 1'b0, 10};
        tbl[5]  = '{7402, 7402, 6'h00, 6'h00, 6'h00, 6'h0F, 6'h00, 1'b1, 1'b0, 1'b0, 0};
        tbl[6]  = '{7486, 7486, 6'h00, 6'h00, 6'h00, 6'h0F, 6'h00, 1'b1, 1'b0, 1'b0, 0};
        tbl[7]  = '{7404, 7404, 6'h00, 6'h20, 6'h00, 6'h1F, 6'h20, 1'b0, 1'b1, 1'b0, 0};
        tbl[8]  = '{7486, 7432, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0F, 1'b0, 1'b1, 1'b0, 0};
        tbl[9]  = '{0,    0,    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 0};
        tbl[10] = '{7432, 7432, 6'h00, 6'h01, 6'h00, 6'h0E, 6'h01, 1'b0, 1'b1, 1'b0, 0};

        Rkey      = 1'b0;
        start     = 1'b0;
        ic_number = 32'd0;
        chip      = 0;
        s1        = 6'd0;
        s0        = 6'd0;
        junk      = 6'd0;
        #23;
        chk("reset_outputs", {busy, done, unsupported, pass, fail, drv_a, drv_b, pass_vec, fail_vec}, 32'd0);
        @(negedge clk);
        Rkey = 1'b1;

        for (int i = 0; i < 11; i++) begin
            tbl[i].jk = 6'($urandom);
            do_run(tbl[i]);
        end

        // Abort during SETTLE of vector 2, then a clean 7432 run.
        chip = 7408;
        s1   = 6'd0;
        s0   = 6'd0;
        @(posedge clk);
        #1 start = 1'b1;
        ic_number = 32'd7408;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_abort_state", {busy, drv_a}, {1'b1, 6'h0F});
        #2 Rkey = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, unsupported, pass, fail, drv_a, drv_b, pass_vec, fail_vec}, 32'd0);
        @(negedge clk);
        Rkey = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", {busy, done}, 32'd0);
        rr = '{7432, 7432, 6'h00, 6'h00, 6'h2A, 6'h0F, 6'h00, 1'b1, 1'b0, 1'b0, 0};
        do_run(rr);

        for (int n = 0; n < 40; n++) begin
            rr.ic     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 99999))
                                                    : parts[$urandom_range(0, 5)];
            rr.chip   = ($urandom_range(0, 4) == 0) ? parts[$urandom_range(0, 5)] : rr.ic;
            rr.s1     = ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
            rr.s0     = ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
            rr.jk     = 6'($urandom);
            rr.inject = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 20)) : 0;
            rr        = with_model(rr);
            do_run(rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
